// File: rtl/median_scan_ctrl.sv
// rtl/median_scan_ctrl.sv - raster scan controller feeding 3x3 windows to a median datapath
module median_scan_ctrl #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int AW    = 19
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [7:0]    rd_data,
    output logic          pix_we,
    output logic [3:0]    pix_idx,
    output logic [7:0]    pix_data,
    output logic          win_valid,
    input  logic          med_valid,
    input  logic [7:0]    med_data,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [7:0]    wr_data,
    input  logic          wr_ready
);

    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [XW-1:0] X_MAX = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(IMG_H - 1);
    localparam logic [AW-1:0] W_A   = AW'(IMG_W);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        WAIT,
        WRITE,
        FIN
    } state_t;

    state_t        state;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [3:0]    tap;

    logic [XW-1:0] next_x;
    logic [YW-1:0] next_y;
    logic          last_pix;

    // Tap k sits at (k/3-1, k%3-1) around (px,py); edges replicate the border pixel.
    function automatic logic [AW-1:0] tap_addr(input logic [XW-1:0] px,
                                               input logic [YW-1:0] py,
                                               input logic [3:0]    k);
        logic [XW-1:0] cx;
        logic [YW-1:0] cy;
        cx = px;
        cy = py;
        case (k)
            4'd0, 4'd3, 4'd6: if (px != '0) cx = px - 1'b1;
            4'd2, 4'd5, 4'd8: if (px != X_MAX) cx = px + 1'b1;
            default: ;
        endcase
        case (k)
            4'd0, 4'd1, 4'd2: if (py != '0) cy = py - 1'b1;
            4'd6, 4'd7, 4'd8: if (py != Y_MAX) cy = py + 1'b1;
            default: ;
        endcase
        return AW'(cy) * W_A + AW'(cx);
    endfunction

    always_comb begin
        last_pix = (x == X_MAX) && (y == Y_MAX);
        next_x   = x + 1'b1;
        next_y   = y;
        if (x == X_MAX) begin
            next_x = '0;
            next_y = y + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            x         <= '0;
            y         <= '0;
            tap       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            pix_we    <= 1'b0;
            pix_idx   <= '0;
            pix_data  <= '0;
            win_valid <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            // The source answers each read by the following edge, so the tap
            // strobe simply trails rd_en by one cycle.
            pix_we    <= rd_en;
            if (rd_en) begin
                pix_idx  <= tap;
                pix_data <= rd_data;
            end
            done      <= 1'b0;
            win_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        x       <= '0;
                        y       <= '0;
                        tap     <= '0;
                        busy    <= 1'b1;
                        rd_en   <= 1'b1;
                        rd_addr <= tap_addr(XW'(0), YW'(0), 4'd0);
                        state   <= FETCH;
                    end
                end
                FETCH: begin
                    if (tap == 4'd8) begin
                        rd_en <= 1'b0;
                        state <= LOAD;
                    end else begin
                        tap     <= tap + 4'd1;
                        rd_addr <= tap_addr(x, y, tap + 4'd1);
                    end
                end
                LOAD: begin
                    win_valid <= 1'b1;
                    state     <= WAIT;
                end
                WAIT: begin
                    if (med_valid) begin
                        wr_data <= med_data;
                        wr_addr <= AW'(y) * W_A + AW'(x);
                        wr_en   <= 1'b1;
                        state   <= WRITE;
                    end
                end
                WRITE: begin
                    if (wr_ready) begin
                        wr_en <= 1'b0;
                        if (last_pix) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= FIN;
                        end else begin
                            x       <= next_x;
                            y       <= next_y;
                            tap     <= '0;
                            rd_en   <= 1'b1;
                            rd_addr <= tap_addr(next_x, next_y, 4'd0);
                            state   <= FETCH;
                        end
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_median_scan_ctrl.sv
// tb/tb_median_scan_ctrl.sv - randomized scoreboard bench for median_scan_ctrl on a 4x3 frame
module tb_median_scan_ctrl;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int AW = 8;
    localparam int N  = W * H;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy;
    logic          done;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic          pix_we;
    logic [3:0]    pix_idx;
    logic [7:0]    pix_data;
    logic          win_valid;
    logic          med_valid;
    logic [7:0]    med_data;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          wr_ready;

    median_scan_ctrl #(.IMG_W(W), .IMG_H(H), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .pix_we(pix_we), .pix_idx(pix_idx), .pix_data(pix_data),
        .win_valid(win_valid), .med_valid(med_valid), .med_data(med_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready)
    );

    initial forever #5 clk = ~clk;

    logic [7:0] mem [0:N-1];
    assign rd_data = (rd_en && int'(rd_addr) < N) ? mem[rd_addr] : 8'h00;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int exp_rd[$];
    int exp_pix[$];
    int exp_wr[$];

    bit checking   = 0;
    bit spur_med   = 0;
    bit rand_ready = 0;
    bit stall_arm  = 0;
    int stall_n    = 0;
    int stall_seen = 0;
    int nwr        = 0;
    int ndone      = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        total++;
        bad++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    function automatic int clampi(input int v, input int lim);
        return (v < 0) ? 0 : ((v > lim - 1) ? lim - 1 : v);
    endfunction

    // Reference: every pixel in raster order reads its border-clamped 3x3
    // neighbourhood and writes the middle of the sorted nine values.
    task automatic push_frame();
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                int v[$];
                v = {};
                for (int k = 0; k < 9; k++) begin
                    int a;
                    a = clampi(y + k / 3 - 1, H) * W + clampi(x + k % 3 - 1, W);
                    exp_rd.push_back(a);
                    exp_pix.push_back(k * 256 + int'(mem[a]));
                    v.push_back(int'(mem[a]));
                end
                v.sort();
                exp_wr.push_back((y * W + x) * 256 + v[4]);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Median datapath and write-sink model.
    initial begin
        int win[0:15];
        int cd;
        int q[$];
        med_valid = 1'b0;
        med_data  = 8'h00;
        wr_ready  = 1'b1;
        cd        = 0;
        for (int i = 0; i < 16; i++) win[i] = 0;
        forever begin
            tick();
            med_valid = 1'b0;
            if (pix_we) win[pix_idx] = int'(pix_data);
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    q = {};
                    for (int k = 0; k < 9; k++) q.push_back(win[k]);
                    q.sort();
                    med_valid = 1'b1;
                    med_data  = 8'(q[4]);
                end
            end else if (spur_med && rd_en && $urandom_range(0, 2) == 0) begin
                med_valid = 1'b1;
                med_data  = 8'($urandom);
            end
            if (win_valid) cd = 3;
            if (stall_arm && wr_en && int'(wr_addr) == 2 && stall_n < 5) begin
                wr_ready = 1'b0;
                stall_n++;
            end else begin
                wr_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a strobe.
    initial begin
        bit prev_rd;
        bit wr_pend;
        int t0, nrd, last_wr, e;
        logic [AW-1:0] held_addr;
        logic [7:0]    held_data;
        prev_rd = 0; wr_pend = 0; t0 = 0; nrd = 0; last_wr = 0;
        held_addr = '0; held_data = '0;
        forever begin
            @(negedge clk);
            if (checking) begin
                if (rd_en) begin
                    if (!prev_rd) begin
                        t0  = cyc;
                        nrd = 0;
                    end
                    nrd++;
                    if (exp_rd.size() == 0) flag("rd_unexpected");
                    else begin
                        e = exp_rd.pop_front();
                        chk("rd_addr", rd_addr, e);
                    end
                end
                if (pix_we) begin
                    chk("pix_lag", prev_rd, 1);
                    if (exp_pix.size() == 0) flag("pix_unexpected");
                    else begin
                        e = exp_pix.pop_front();
                        chk("pix_idx", pix_idx, e / 256);
                        chk("pix_data", pix_data, e % 256);
                    end
                end
                if (win_valid) begin
                    chk("win_latency", cyc - t0, 10);
                    chk("win_reads", nrd, 9);
                end
                if (wr_en) begin
                    if (wr_pend) begin
                        chk("wr_addr_stable", wr_addr, held_addr);
                        chk("wr_data_stable", wr_data, held_data);
                    end
                    if (stall_arm && int'(wr_addr) == 2) stall_seen++;
                    if (wr_ready) begin
                        nwr++;
                        last_wr = cyc;
                        wr_pend = 0;
                        if (exp_wr.size() == 0) flag("wr_unexpected");
                        else begin
                            e = exp_wr.pop_front();
                            chk("wr_addr", wr_addr, e / 256);
                            chk("wr_data", wr_data, e % 256);
                        end
                    end else begin
                        wr_pend   = 1;
                        held_addr = wr_addr;
                        held_data = wr_data;
                    end
                end
                if ((rd_en || wr_en || pix_we || win_valid) && !busy) flag("strobe_not_busy");
                if (done) begin
                    ndone++;
                    chk("done_latency", cyc - last_wr, 1);
                    chk("busy_with_done", busy, 0);
                end
                prev_rd = rd_en;
            end
        end
    end

    task automatic new_image();
        for (int i = 0; i < N; i++) mem[i] = 8'($urandom);
    endtask

    task automatic run_frame(input bit spur_start);
        int n, w0, d0;
        w0 = nwr;
        d0 = ndone;
        push_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        n = 0;
        while (!done && n < 5000) begin
            tick();
            n++;
            start = spur_start && busy && !done && ($urandom_range(0, 5) == 0);
        end
        start = 1'b0;
        if (!done) flag("done_timeout");
        tick();
        tick();
        chk("frame_writes", nwr - w0, N);
        chk("frame_done_pulses", ndone - d0, 1);
        chk("wr_queue_empty", exp_wr.size(), 0);
        chk("rd_queue_empty", exp_rd.size(), 0);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        int n, quiet;
        rst   = 1'b1;
        start = 1'b0;
        for (int i = 0; i < N; i++) mem[i] = 8'h00;
        repeat (3) tick();
        chk("reset_strobes", {busy, done, rd_en, pix_we, win_valid, wr_en}, 0);
        chk("reset_addrs", {rd_addr, wr_addr}, 0);
        chk("reset_data", {pix_idx, pix_data, wr_data}, 0);
        rst = 1'b0;
        checking = 1;
        tick();

        // Frame 1: corner/interior windows, 5-cycle stall on address 2.
        new_image();
        stall_arm  = 1;
        stall_n    = 0;
        stall_seen = 0;
        run_frame(0);
        chk("stall_wr_cycles", stall_seen, 6);
        stall_arm = 0;

        // Frame 2: random backpressure, spurious start and med_valid.
        new_image();
        rand_ready = 1;
        spur_med   = 1;
        run_frame(1);

        // Frame 3: abort with reset during FETCH of pixel 5.
        new_image();
        rand_ready = 0;
        spur_med   = 0;
        push_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (exp_wr.size() > N - 5 && n < 3000) begin
            tick();
            n++;
        end
        while (!rd_en && n < 3000) begin
            tick();
            n++;
        end
        if (n >= 3000) flag("abort_wait_timeout");
        repeat (3) tick();
        chk("abort_in_fetch", rd_en, 1);
        rst   = 1'b1;
        start = 1'b1;
        tick();
        chk("abort_strobes", {busy, done, rd_en, pix_we, win_valid, wr_en}, 0);
        chk("abort_addrs", {rd_addr, wr_addr}, 0);
        chk("abort_data", {pix_idx, pix_data, wr_data}, 0);
        exp_rd.delete();
        exp_pix.delete();
        exp_wr.delete();
        rst   = 1'b0;
        start = 1'b0;
        quiet = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (rd_en || wr_en || pix_we || win_valid || done || busy) quiet++;
        end
        chk("abort_quiet", quiet, 0);

        // Frame 4: restart from address 0 under random conditions.
        new_image();
        rand_ready = 1;
        spur_med   = 1;
        run_frame(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/median_scan_ctrl.md
MEDIAN_SCAN_CTRL -- requirements
Module: median_scan_ctrl

Interface
REQ-001 Parameter IMG_W, default 640, frame width in pixels (IMG_W >= 2).
REQ-002 Parameter IMG_H, default 480, frame height in pixels (IMG_H >= 2).
REQ-003 Parameter AW, default 19, pixel address width; IMG_W*IMG_H SHALL fit in AW bits.
REQ-004 Ports SHALL be:
- clk  in  1  single clock, all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to filter one frame.
- busy  out  1  high from the accepted start until done.
- done  out  1  one-cycle pulse after the last pixel is written.
- rd_en  out  1  source-frame read strobe.
- rd_addr  out  AW  source-frame read address.
- rd_data  in  8  source pixel, valid exactly 1 cycle after rd_en.
- pix_we  out  1  window-tap load strobe to the median datapath.
- pix_idx  out  4  tap index 0..8, row-major, top-left first.
- pix_data  out  8  tap value (registered rd_data).
- win_valid  out  1  one-cycle pulse: all 9 taps loaded, start sort.
- med_valid  in  1  median datapath result strobe.
- med_data  in  8  median result.
- wr_en  out  1  result write request.
- wr_addr  out  AW  destination address, y*IMG_W+x.
- wr_data  out  8  median value to write.
- wr_ready  in  1  destination accepts when wr_en && wr_ready.

Function
REQ-005 FSM states SHALL be IDLE, FETCH, LOAD, WAIT, WRITE, FIN.
REQ-006 IDLE: start=1 -> x=0, y=0, tap=0, busy=1, go to FETCH next cycle; start while busy SHALL be ignored.
REQ-007 FETCH: 9 consecutive cycles with rd_en=1, tap k=0..8 at offset (dy,dx) = (k/3-1, k%3-1).
REQ-008 Tap coordinates SHALL clamp to the frame: cx = min(max(x+dx,0),IMG_W-1), same for cy; rd_addr = cy*IMG_W+cx.
REQ-009 Each read SHALL return as pix_we=1, pix_idx=k, pix_data=rd_data exactly one cycle after its rd_en.
REQ-010 LOAD: the cycle after tap 8 data returns -> win_valid=1 for one cycle, then WAIT.
REQ-011 Per-pixel fixed latency: first rd_en at cycle 0, last pix_we at cycle 9, win_valid at cycle 10.
REQ-012 WAIT: hold until med_valid=1; capture med_data into wr_data, go WRITE; med_valid outside WAIT SHALL be ignored.
REQ-013 WRITE: wr_en=1 with stable wr_addr/wr_data until wr_ready=1; the handshake cycle completes the pixel.
REQ-014 Pixel advance on write completion: x==IMG_W-1 -> x=0, y=y+1; else x=x+1; then FETCH.
REQ-015 Write completion at x=IMG_W-1, y=IMG_H-1 -> FIN: done=1 one cycle, busy=0, return to IDLE next cycle.
REQ-016 Every pixel SHALL be written exactly once, in raster order, addresses 0..IMG_W*IMG_H-1.
REQ-017 rd_en, pix_we, win_valid, wr_en SHALL never be asserted in IDLE or FIN.
REQ-018 Address arithmetic SHALL be unsigned, AW bits, with no overflow for legal parameters.

Reset
REQ-019 rst=1 SHALL force state IDLE, x=y=tap=0, and all outputs 0 (busy, done, rd_en, rd_addr, pix_we, pix_idx, pix_data, win_valid, wr_en, wr_addr, wr_data) on the next edge.
REQ-020 rst in any state, including mid-FETCH or WRITE with wr_ready low, SHALL abort the frame with no further strobes; start in the same cycle as rst SHALL be ignored.

Verification (IMG_W=4, IMG_H=3, 1-cycle memory model, datapath model returns med_valid 3 cycles after win_valid)
REQ-021 Corner: start -> pixel (0,0) rd_addr sequence 0,0,1,0,0,1,4,4,5; wr_addr=0 with the true 3x3 median of the clamped window.
REQ-022 Interior: pixel (1,1) -> rd_addr 0,1,2,4,5,6,8,9,10; pix_idx 0..8 one cycle behind; win_valid at cycle 10.
REQ-023 Backpressure: hold wr_ready=0 for 5 cycles at pixel (2,0) -> wr_en, wr_addr=2, wr_data stable for all 6 cycles; exactly one write.
REQ-024 Full frame: 12 writes, wr_addr 0..11 in order; done pulses once, 1 cycle after the write of address 11; busy falls with done.
REQ-025 Reset mid-op: rst asserted during FETCH of pixel 5 -> all outputs 0 next cycle, no further rd_en/wr_en; new start restarts at address 0.
REQ-026 Spurious inputs: start while busy and med_valid during FETCH -> no effect on write sequence or count.
